// File: rtl/uart_alu_pkg.sv
// Shared framing constants and opcode/state encodings for the UART packet ALU.
// Opcode values are fixed by the host tooling and must not change.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        ECHO = 8'hEC,
        ADD  = 8'hAD,
        MUL  = 8'h88
    } opcode_e;

    typedef enum logic [2:0] {
        HDR_OP,
        HDR_RSV,
        HDR_LEN0,
        HDR_LEN1,
        PAYLOAD,
        SEND
    } state_e;

    localparam int HDR_BYTES = 4;

    function automatic logic op_known(input logic [7:0] op);
        return (op == ECHO) || (op == ADD) || (op == MUL);
    endfunction

endpackage

// File: rtl/uart_alu_txser.sv
// Parallel-in, byte-out AXIS serializer: sends NB bytes LSB first after a load pulse.
// The shift register only moves on a handshake, so tdata holds steady while stalled.
module uart_alu_txser #(
    parameter int NB = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load,
    input  logic [NB*8-1:0] din,
    output logic [7:0]      tdata,
    output logic            tvalid,
    input  logic            tready,
    output logic            busy,
    output logic            done
);
    localparam int BW = $clog2(NB + 1);

    logic [NB*8-1:0] sr;
    logic [BW-1:0]   rem;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr     <= '0;
            rem    <= '0;
            tvalid <= 1'b0;
        end else if (load) begin
            sr     <= din;
            rem    <= BW'(NB - 1);
            tvalid <= 1'b1;
        end else if (tvalid && tready) begin
            if (rem == '0) begin
                tvalid <= 1'b0;
            end else begin
                sr  <= sr >> 8;
                rem <= rem - 1'b1;
            end
        end
    end

    assign tdata = sr[7:0];
    assign busy  = tvalid;
    assign done  = tvalid && tready && (rem == '0);

endmodule

// File: rtl/uart_alu_engine.sv
// Packet ALU between UART RX and TX byte streams: parses a 4-byte header, then
// echoes the payload or folds it into one ADD/MUL result returned little-endian.
module uart_alu_engine
    import uart_alu_pkg::*;
#(
    parameter int OP_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy_o,
    output logic       err_o
);
    localparam int          NB      = OP_WIDTH / 8;
    localparam int          BW      = $clog2(NB + 1);
    localparam logic [15:0] HDR_LEN = 16'(HDR_BYTES);

    state_e              state;
    logic [7:0]          op_q, len_lo;
    logic [15:0]         cnt, len_w;
    logic [OP_WIDTH-1:0] acc, opnd;
    logic [BW-1:0]       bidx;
    logic                upd, rdy, s_fire, is_echo, is_arith;
    logic [7:0]          ech_d, tx_data;
    logic                ech_v, tx_vld, tx_busy, tx_done, tx_load;

    assign len_w    = {s_axis_tdata, len_lo};
    assign is_echo  = (op_q == ECHO);
    assign is_arith = (op_q == ADD) || (op_q == MUL);

    // Unknown opcodes still drain their payload, so they accept whenever bytes remain.
    always_comb begin
        rdy = 1'b0;
        case (state)
            HDR_OP, HDR_RSV, HDR_LEN0, HDR_LEN1: rdy = 1'b1;
            PAYLOAD: begin
                if (cnt != '0) begin
                    if (is_arith)     rdy = ~upd;
                    else if (is_echo) rdy = ~ech_v | m_axis_tready;
                    else              rdy = 1'b1;
                end
            end
            default: rdy = 1'b0;
        endcase
    end

    assign s_axis_tready = rdy & ~reset_i;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign tx_load       = (state == SEND) & ~tx_busy;
    assign busy_o        = (state != HDR_OP);
    assign m_axis_tvalid = tx_vld | ech_v;
    assign m_axis_tdata  = tx_vld ? tx_data : ech_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= HDR_OP;
            op_q   <= '0;
            len_lo <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            bidx   <= '0;
            upd    <= 1'b0;
            ech_d  <= '0;
            ech_v  <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (ech_v && m_axis_tready) ech_v <= 1'b0;
            case (state)
                HDR_OP: if (s_fire) begin
                    op_q  <= s_axis_tdata;
                    acc   <= (s_axis_tdata == MUL) ? OP_WIDTH'(1) : '0;
                    opnd  <= '0;
                    bidx  <= '0;
                    upd   <= 1'b0;
                    state <= HDR_RSV;
                end
                HDR_RSV: if (s_fire) state <= HDR_LEN0;
                HDR_LEN0: if (s_fire) begin
                    len_lo <= s_axis_tdata;
                    state  <= HDR_LEN1;
                end
                HDR_LEN1: if (s_fire) begin
                    cnt <= len_w - HDR_LEN;
                    if (len_w < HDR_LEN) begin
                        err_o <= 1'b1;
                        state <= HDR_OP;
                    end else begin
                        if (!op_known(op_q)) err_o <= 1'b1;
                        if (len_w != HDR_LEN) state <= PAYLOAD;
                        else if (is_arith)    state <= SEND;
                        else                  state <= HDR_OP;
                    end
                end
                PAYLOAD: begin
                    if (is_arith) begin
                        // One dedicated cycle per operand keeps the multiplier off the byte path.
                        if (upd) begin
                            acc   <= (op_q == MUL) ? acc * opnd : acc + opnd;
                            opnd  <= '0;
                            bidx  <= '0;
                            upd   <= 1'b0;
                            if (cnt == '0) state <= SEND;
                        end else if (s_fire) begin
                            for (int i = 0; i < NB; i++)
                                if (bidx == BW'(i)) opnd[i*8 +: 8] <= s_axis_tdata;
                            bidx <= bidx + 1'b1;
                            cnt  <= cnt - 1'b1;
                            if (bidx == BW'(NB - 1) || cnt == 16'd1) upd <= 1'b1;
                        end
                    end else if (is_echo) begin
                        if (s_fire) begin
                            ech_d <= s_axis_tdata;
                            ech_v <= 1'b1;
                            cnt   <= cnt - 1'b1;
                        end else if (cnt == '0 && (!ech_v || m_axis_tready)) begin
                            state <= HDR_OP;
                        end
                    end else if (s_fire) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == 16'd1) state <= HDR_OP;
                    end
                end
                SEND: if (tx_done) state <= HDR_OP;
                default: state <= HDR_OP;
            endcase
        end
    end

    uart_alu_txser #(.NB(NB)) u_txser (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load   (tx_load),
        .din    (acc),
        .tdata  (tx_data),
        .tvalid (tx_vld),
        .tready (m_axis_tready),
        .busy   (tx_busy),
        .done   (tx_done)
    );

endmodule

// File: tb/tb_uart_alu_engine.sv
// Randomized packet bench for uart_alu_engine against a queue-based packet model.
module tb_uart_alu_engine;
    typedef logic [7:0] bq_t[$];

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready;
    logic       busy_o, err_o;

    always #5 clk_i = ~clk_i;

    uart_alu_engine #(.OP_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    int         n_vec, n_bad, err_cnt, stall_left;
    bit         stall_arm, hold, s_fire;
    logic [7:0] hold_d;
    bq_t        out_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at negedge+1; samples what the coming posedge will do, then steps to the next negedge+1.
    task automatic cycle();
        if (stall_arm && out_q.size() == 1) begin
            stall_left = 5;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tready = ($urandom_range(3) != 0);
        end
        #1;
        if (hold && !reset_i)
            check("tx_hold", 32'({m_axis_tvalid, m_axis_tdata}), 32'({1'b1, hold_d}));
        hold   = m_axis_tvalid && !m_axis_tready && !reset_i;
        hold_d = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready && !reset_i) out_q.push_back(m_axis_tdata);
        if (err_o) err_cnt++;
        s_fire = s_axis_tvalid && s_axis_tready;
        @(negedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit fired;
        if ($urandom_range(3) == 0)
            repeat ($urandom_range(2) + 1) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'($urandom);
                cycle();
            end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        fired = 1'b0;
        for (int t = 0; t < 2000 && !fired; t++) begin
            cycle();
            fired = s_fire;
        end
        s_axis_tvalid = 1'b0;
        if (!fired) check("rx_timeout", 32'(fired), 32'd1);
    endtask

    task automatic send_pkt(input bq_t p);
        out_q.delete();
        err_cnt = 0;
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic finish_pkt(input string tag, input bq_t exp, input int exp_err);
        int idle = 0;
        for (int t = 0; t < 3000 && idle < 3; t++) begin
            cycle();
            if (!busy_o && !m_axis_tvalid) idle++;
            else idle = 0;
        end
        check({tag, "_drain"}, 32'(idle), 32'd3);
        check({tag, "_nbytes"}, 32'(out_q.size()), 32'(exp.size()));
        foreach (exp[i])
            if (i < out_q.size()) check({tag, "_byte"}, 32'(out_q[i]), 32'(exp[i]));
        check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic run_pkt(input string tag, input bq_t p, input bq_t exp, input int exp_err);
        send_pkt(p);
        finish_pkt(tag, exp, exp_err);
    endtask

    // Packet-level reference: operands are NB-byte little-endian chunks of the payload.
    function automatic void model(input bq_t p, output bq_t out, output int err);
        logic [7:0]  op;
        int          len;
        logic [63:0] acc, opnd;
        out = {};
        err = 0;
        op  = p[0];
        len = int'({p[3], p[2]});
        if (len < 4 || !(op == 8'hEC || op == 8'hAD || op == 8'h88)) begin
            err = 1;
            return;
        end
        if (op == 8'hEC) begin
            for (int i = 4; i < len; i++) out.push_back(p[i]);
        end else begin
            acc = (op == 8'h88) ? 64'd1 : 64'd0;
            for (int k = 4; k < len; k += 4) begin
                opnd = 0;
                for (int j = 0; j < 4; j++)
                    if (k + j < len) opnd |= 64'(p[k+j]) << (8 * j);
                acc = (op == 8'hAD) ? (acc + opnd) : (acc * opnd);
                acc &= 64'hFFFF_FFFF;
            end
            for (int j = 0; j < 4; j++) out.push_back(8'(acc >> (8 * j)));
        end
    endfunction

    function automatic bq_t mk_pkt(input logic [7:0] op, input logic [15:0] len);
        bq_t p;
        p = {op, 8'($urandom), len[7:0], len[15:8]};
        for (int i = 4; i < int'(len); i++) p.push_back(8'($urandom));
        return p;
    endfunction

    initial begin
        bq_t p, e, none;
        int  ee, pick;
        logic [7:0]  op;
        logic [15:0] len;
        n_vec = 0; n_bad = 0; err_cnt = 0; stall_left = 0;
        stall_arm = 0; hold = 0; s_fire = 0; hold_d = '0;
        none = {};
        reset_i = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        @(negedge clk_i);
        #1;
        repeat (3) cycle();
        reset_i = 1'b0;
        #1;
        check("rst_tready", 32'(s_axis_tready), 32'd1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        out_q.delete();

        run_pkt("add", {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                        8'h02, 8'h00, 8'h00, 8'h00}, {8'h03, 8'h00, 8'h00, 8'h00}, 0);
        run_pkt("mul", {8'h88, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                        8'h02, 8'h00, 8'h00, 8'h00}, {8'hFE, 8'hFF, 8'hFF, 8'hFF}, 0);
        run_pkt("partial", {8'hAD, 8'h00, 8'h07, 8'h00, 8'h05, 8'h01, 8'h02},
                {8'h05, 8'h01, 8'h02, 8'h00}, 0);
        run_pkt("mul_empty", {8'h88, 8'h00, 8'h04, 8'h00}, {8'h01, 8'h00, 8'h00, 8'h00}, 0);
        stall_arm = 1'b1;
        run_pkt("echo_stall", {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43},
                {8'h41, 8'h42, 8'h43}, 0);
        run_pkt("bad_op", {8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22}, none, 1);
        run_pkt("bad_len", {8'hAD, 8'h00, 8'h02, 8'h00}, none, 1);
        run_pkt("after_err", {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                              8'h02, 8'h00, 8'h00, 8'h00}, {8'h03, 8'h00, 8'h00, 8'h00}, 0);

        // Result timing: last payload byte at edge N, tvalid rises after edge N+2.
        send_pkt({8'hAD, 8'h00, 8'h08, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40});
        check("lat_n", 32'(m_axis_tvalid), 32'd0);
        cycle();
        check("lat_n1", 32'(m_axis_tvalid), 32'd0);
        cycle();
        check("lat_n2", 32'(m_axis_tvalid), 32'd1);
        finish_pkt("lat", {8'h10, 8'h20, 8'h30, 8'h40}, 0);

        // Reset in the middle of an ADD packet.
        send_pkt({8'hAD, 8'h00, 8'h0C, 8'h00, 8'h07, 8'h00});
        reset_i = 1'b1;
        s_axis_tvalid = 1'b1;
        cycle();
        check("rstmid_tready", 32'(s_fire), 32'd0);
        reset_i = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("rstmid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rstmid_busy", 32'(busy_o), 32'd0);
        check("rstmid_tready1", 32'(s_axis_tready), 32'd1);
        run_pkt("post_rst", {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                             8'h06, 8'h00, 8'h00, 8'h01}, {8'h0B, 8'h00, 8'h00, 8'h01}, 0);

        // Long packet exercising the length high byte.
        p = mk_pkt(8'hAD, 16'h0104);
        model(p, e, ee);
        run_pkt("long_add", p, e, ee);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(9);
            if (pick < 3)      op = 8'hEC;
            else if (pick < 6) op = 8'hAD;
            else if (pick < 9) op = 8'h88;
            else               op = 8'($urandom_range(127));
            len = ($urandom_range(7) == 0) ? 16'($urandom_range(3)) : 16'($urandom_range(20, 4));
            p = mk_pkt(op, len);
            model(p, e, ee);
            run_pkt("rand", p, e, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
